// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial pattern detector.
package seq_det_pkg;

  // Detector state, derived from how many valid history bits are held.
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    ARMED   = 2'd2
  } seq_state_t;

  // Pattern loaded at reset when the instantiating block does not override it.
  localparam logic [3:0] DEFAULT_PAT = 4'b1011;

  // Width of the fill counter: must hold values 0..pat_w-1.
  function automatic int fill_width(input int pat_w);
    return (pat_w < 2) ? 1 : $clog2(pat_w);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a sticky "reached all-ones" flag.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             _rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Clear wins over increment; the count never wraps past all-ones.
  always_ff @(posedge clk) begin
    if (!_rst) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
      if ((cnt + CNT_W'(1)) == CNT_MAX) begin
        sat <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector with a programmable PAT_W-bit pattern.
//
// Input qualification: `en` is a valid strobe for `D`; a sample is consumed on
// every rising edge where en=1 and pat_load=0. There is no backpressure, so a
// sample presented with en=1 is never stalled, only dropped by pat_load.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int               PAT_W     = 4,
  parameter logic [PAT_W-1:0] PAT_RESET = PAT_W'(DEFAULT_PAT),
  parameter bit               OVERLAP   = 1'b1,
  parameter int               CNT_W     = 8
) (
  input  logic             clk,
  input  logic             _rst,
  input  logic             en,
  input  logic             D,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             Q,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat,
  output logic             armed
);

  localparam int             FW       = fill_width(PAT_W);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W - 1);

  // Only the PAT_W-1 most recent bits need storing; the incoming D completes
  // the window that is compared against the pattern.
  logic [PAT_W-2:0] hist;
  logic [PAT_W-2:0] hist_nxt;
  logic [FW-1:0]    fill;
  logic [FW-1:0]    fill_nxt;
  logic [PAT_W-1:0] pat_q;
  logic [PAT_W-1:0] pat_nxt;
  logic [PAT_W-1:0] window;
  seq_state_t       state;
  logic             hit;

  // State register: history, fill level, pattern and the match pulse.
  always_ff @(posedge clk) begin
    if (!_rst) begin
      hist  <= '0;
      fill  <= '0;
      pat_q <= PAT_RESET;
      Q     <= 1'b0;
    end else begin
      hist  <= hist_nxt;
      fill  <= fill_nxt;
      pat_q <= pat_nxt;
      Q     <= hit;
    end
  end

  // Decode state from fill, evaluate the match and compute the next history.
  always_comb begin
    state    = EMPTY;
    hist_nxt = hist;
    fill_nxt = fill;
    pat_nxt  = pat_q;
    window   = {hist, D};
    hit      = 1'b0;

    // Any fill value outside 0..PAT_W-1 decodes as EMPTY.
    if (fill == FILL_MAX) begin
      state = ARMED;
    end else if ((fill != '0) && (fill < FILL_MAX)) begin
      state = FILLING;
    end

    hit = en && !pat_load && (state == ARMED) && (window == pat_q);

    if (pat_load) begin
      // New pattern invalidates any partial history; the en sample is dropped.
      pat_nxt  = pat_in;
      hist_nxt = '0;
      fill_nxt = '0;
    end else if ((state == EMPTY) && (fill != '0)) begin
      // Illegal fill value: recover to a clean EMPTY.
      hist_nxt = '0;
      fill_nxt = '0;
    end else if (en) begin
      hist_nxt = window[PAT_W-2:0];
      if (hit && !OVERLAP) begin
        fill_nxt = '0;
      end else if (fill != FILL_MAX) begin
        fill_nxt = fill + FW'(1);
      end
    end
  end

  assign armed = (state == ARMED);

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk  (clk),
    ._rst (_rst),
    .clr  (cnt_clr),
    .inc  (hit),
    .cnt  (match_cnt),
    .sat  (cnt_sat)
  );

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: three instances (overlapping, non-overlapping,
// 2-bit counter) share one stimulus stream and are checked every cycle.
module tb_seq_pattern_detector;

  localparam int W = 4;

  // ---------------- clock / reset block ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         en;
  logic         d;
  logic         pat_load;
  logic [W-1:0] pat_in;
  logic         cnt_clr;

  logic       q0, q1, q2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
  logic       sat0, sat1, sat2;
  logic       arm0, arm1, arm2;

  seq_pattern_detector #(.PAT_W(W), .OVERLAP(1'b1), .CNT_W(8)) dut_ov (
    .clk(clk), ._rst(rst_n), .en(en), .D(d), .pat_load(pat_load), .pat_in(pat_in),
    .cnt_clr(cnt_clr), .Q(q0), .match_cnt(cnt0), .cnt_sat(sat0), .armed(arm0));

  seq_pattern_detector #(.PAT_W(W), .OVERLAP(1'b0), .CNT_W(8)) dut_nov (
    .clk(clk), ._rst(rst_n), .en(en), .D(d), .pat_load(pat_load), .pat_in(pat_in),
    .cnt_clr(cnt_clr), .Q(q1), .match_cnt(cnt1), .cnt_sat(sat1), .armed(arm1));

  seq_pattern_detector #(.PAT_W(W), .OVERLAP(1'b1), .CNT_W(2)) dut_c2 (
    .clk(clk), ._rst(rst_n), .en(en), .D(d), .pat_load(pat_load), .pat_in(pat_in),
    .cnt_clr(cnt_clr), .Q(q2), .match_cnt(cnt2), .cnt_sat(sat2), .armed(arm2));

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;

  // Every valid bit since the last reset or pattern load, oldest first.
  bit           stream[$];
  // Valid bits seen by the non-overlapping detector since its last clear.
  int           nov_len;
  logic [W-1:0] m_pat;
  int           m_cnt[3];

  function automatic int cnt_max(input int k);
    return (k == 2) ? 3 : 255;
  endfunction

  // True when the newest W bits of the stream spell the pattern (MSB first).
  function automatic bit tail_matches();
    int n;
    n = stream.size();
    if (n < W) return 1'b0;
    for (int i = 0; i < W; i++) begin
      if (stream[n - W + i] != m_pat[W - 1 - i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver task ----------------
  // Drives one edge, advances the model, then compares all outputs.
  task automatic cycle(input bit r, input bit e, input bit dv, input bit ld,
                       input logic [W-1:0] pin, input bit clr);
    bit ho;
    bit hn;
    bit hk;
    @(negedge clk);
    rst_n = r; en = e; d = dv; pat_load = ld; pat_in = pin; cnt_clr = clr;
    ho = 1'b0;
    hn = 1'b0;
    if (!r) begin
      stream.delete();
      nov_len = 0;
      m_pat   = 4'b1011;
      m_cnt   = '{0, 0, 0};
    end else begin
      if (ld) begin
        m_pat = pin;
        stream.delete();
        nov_len = 0;
      end else if (e) begin
        stream.push_back(dv);
        if (stream.size() > 32) void'(stream.pop_front());
        if (nov_len < 32) nov_len++;
        ho = tail_matches();
        hn = ho && (nov_len >= W);
        if (hn) nov_len = 0;
      end
      for (int k = 0; k < 3; k++) begin
        hk = (k == 1) ? hn : ho;
        if (clr) m_cnt[k] = 0;
        else if (hk && (m_cnt[k] < cnt_max(k))) m_cnt[k]++;
      end
    end
    @(posedge clk);
    #1;
    check("q_ov",    int'(q0),   int'(ho));
    check("q_nov",   int'(q1),   int'(hn));
    check("q_c2",    int'(q2),   int'(ho));
    check("cnt_ov",  int'(cnt0), m_cnt[0]);
    check("cnt_nov", int'(cnt1), m_cnt[1]);
    check("cnt_c2",  int'(cnt2), m_cnt[2]);
    check("sat_ov",  int'(sat0), (m_cnt[0] == cnt_max(0)) ? 1 : 0);
    check("sat_nov", int'(sat1), (m_cnt[1] == cnt_max(1)) ? 1 : 0);
    check("sat_c2",  int'(sat2), (m_cnt[2] == cnt_max(2)) ? 1 : 0);
    check("arm_ov",  int'(arm0), (stream.size() >= W - 1) ? 1 : 0);
    check("arm_nov", int'(arm1), (nov_len >= W - 1) ? 1 : 0);
    check("arm_c2",  int'(arm2), (stream.size() >= W - 1) ? 1 : 0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit d;
    bit q_ov;
    bit q_nov;
    bit arm_ov;
    bit arm_nov;
  } vec_t;

  vec_t tbl[7];

  // ---------------- main test ----------------
  initial begin
    int   pulses;
    bit   bits4[4];
    logic [W-1:0] pat_0110;

    rst_n = 1'b0; en = 1'b0; d = 1'b0; pat_load = 1'b0; pat_in = '0; cnt_clr = 1'b0;

    // Reset state.
    do_reset();
    check("rst_q",   int'(q0),   0);
    check("rst_cnt", int'(cnt0), 0);
    check("rst_sat", int'(sat0), 0);
    check("rst_arm", int'(arm0), 0);

    // Stream 1,0,1,1,0,1,1 against pattern 1011.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, 1'b1, tbl[i].d, 1'b0, '0, 1'b0);
      check("tbl_q_ov",    int'(q0),   int'(tbl[i].q_ov));
      check("tbl_q_nov",   int'(q1),   int'(tbl[i].q_nov));
      check("tbl_arm_ov",  int'(arm0), int'(tbl[i].arm_ov));
      check("tbl_arm_nov", int'(arm1), int'(tbl[i].arm_nov));
    end
    check("tbl_cnt_ov",  int'(cnt0), 2);
    check("tbl_cnt_nov", int'(cnt1), 1);

    // en toggling: 1,0,1,1 presented only on en=1 cycles.
    do_reset();
    bits4  = '{1'b1, 1'b0, 1'b1, 1'b1};
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, bits4[i], 1'b0, '0, 1'b0);
      if (q0) pulses++;
      check("entog_q_pos", int'(q0), (i == 3) ? 1 : 0);
      cycle(1'b1, 1'b0, ~bits4[i], 1'b0, '0, 1'b0);
      if (q0) pulses++;
    end
    check("entog_pulses", pulses, 1);

    // Pattern load coinciding with the last bit of a 1011 match.
    do_reset();
    cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    pat_0110 = 4'b0110;
    cycle(1'b1, 1'b1, 1'b1, 1'b1, pat_0110, 1'b0);
    check("load_no_q",   int'(q0),   0);
    check("load_no_arm", int'(arm0), 0);
    bits4 = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, bits4[i], 1'b0, '0, 1'b0);
    check("load_new_q",   int'(q0),   1);
    check("load_new_cnt", int'(cnt0), 1);

    // Saturation of the 2-bit counter with pattern 1111 and a run of ones.
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
      check("satrun_q",   int'(q2),   (i >= 3) ? 1 : 0);
      check("satrun_sat", int'(sat2), (i >= 5) ? 1 : 0);
    end
    check("satrun_cnt_c2", int'(cnt2), 3);
    check("satrun_cnt_ov", int'(cnt0), 7);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("clr_cnt", int'(cnt2), 0);
    check("clr_sat", int'(sat2), 0);

    // Reset mid-stream discards partial history.
    do_reset();
    cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    check("midrst_q",   int'(q0),   0);
    check("midrst_arm", int'(arm0), 0);
    check("midrst_cnt", int'(cnt0), 0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 299) != 0),
            ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 59) == 0),
            W'($urandom_range(0, 15)),
            ($urandom_range(0, 79) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule
